cia_multiword_add_seq: RTL and testbench

- Multi-precision adder sequencer: one shared `carry_increment_32_bit` adder computes a WORDS×32-bit sum, one 32-bit word per cycle, least-significant word first.
- Carry is registered between words.
- Sits between a wide-operand requester and the 32-bit carry-increment datapath.
- Provides a start/busy/done handshake so the adder is reused instead of replicated.

---
 rtl/cia_pkg.sv | 14 +
 rtl/carry_increment_32_bit.sv | 23 ++
 rtl/cia_multiword_add_seq.sv | 107 ++++++++++
 tb/tb_cia_multiword_add_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cia_pkg.sv
// Shared constants and state encoding for the multi-word carry-increment adder sequencer.
package cia_pkg;

  localparam int unsigned CIA_WORD_W    = 32;
  localparam int unsigned CIA_WORDS_MIN = 2;
  localparam int unsigned CIA_WORDS_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cia_state_e;

endpackage

// File: rtl/carry_increment_32_bit.sv
// 32-bit carry-increment adder: 8-bit blocks add locally, then increment by the incoming carry.
module carry_increment_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < 4; g++) begin : gen_blk
    logic [8:0] blk_sum;
    assign blk_sum = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]};
    // Max 0x1FE + 1 still fits in 9 bits, so the increment never overflows the block.
    assign {c[g+1], sum[g*8 +: 8]} = blk_sum + {8'b0, c[g]};
  end

  assign cout = c[4];

endmodule

// File: rtl/cia_multiword_add_seq.sv
// Sequences one shared carry_increment_32_bit over WORDS 32-bit words, LSW first.
// Optional subtract support is enabled with CIA_SEQ_SUB_EN.
module cia_multiword_add_seq
  import cia_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WORDS*CIA_WORD_W-1:0] a,
  input  logic [WORDS*CIA_WORD_W-1:0] b,
  input  logic                        cin,
`ifdef CIA_SEQ_SUB_EN
  input  logic                        sub,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [WORDS*CIA_WORD_W-1:0] sum,
  output logic                        cout
);

  localparam int unsigned IdxW = $clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  cia_state_e            state_q;
  logic [IdxW-1:0]       idx_q;
  logic                  carry_q;
  logic [CIA_WORD_W-1:0] a_q [WORDS];
  logic [CIA_WORD_W-1:0] b_q [WORDS];
  logic [CIA_WORD_W-1:0] op_b;
  logic [CIA_WORD_W-1:0] add_sum;
  logic                  add_cout;

`ifdef CIA_SEQ_SUB_EN
  logic sub_q;
  assign op_b = sub_q ? ~b_q[idx_q] : b_q[idx_q];
`else
  assign op_b = b_q[idx_q];
`endif

  carry_increment_32_bit u_adder (
    .a    (a_q[idx_q]),
    .b    (op_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
`ifdef CIA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            for (int i = 0; i < WORDS; i++) begin
              a_q[i] <= a[i*CIA_WORD_W +: CIA_WORD_W];
              b_q[i] <= b[i*CIA_WORD_W +: CIA_WORD_W];
            end
`ifdef CIA_SEQ_SUB_EN
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum[idx_q*CIA_WORD_W +: CIA_WORD_W] <= add_sum;
          carry_q <= add_cout;
          if (idx_q == LastIdx) begin
            cout    <= add_cout;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          // busy stays high through the done cycle and drops in IDLE.
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cia_multiword_add_seq.sv
// Self-checking bench for cia_multiword_add_seq (WORDS=4); subtract cases need CIA_SEQ_SUB_EN.
module tb_cia_multiword_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = WORDS * 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cia_multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef CIA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole-operand arithmetic, {cout, sum} = a + b' + c.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic         c;
    bb = msub ? ~mb : mb;
    c  = msub ? 1'b1 : mcin;
    return {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One operation; start sampled at edge 0, done expected after edge WORDS+1.
  // With hammer=1, start is held high with fresh operands through RUN and DONE.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tcin, input logic tsub, input bit hammer,
                       input logic [W-1:0] exp_sum, input logic exp_cout);
    int done_cnt;
    int first_done;
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = hammer;
    chk({tag, ".busy_rise"}, {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
    done_cnt   = 0;
    first_done = -1;
    for (int cyc = 1; cyc <= WORDS + 5; cyc++) begin
      if (hammer) begin
        a = rnd_op(); b = rnd_op(); cin = ~cin; sub = ~sub;
      end
      @(posedge clk);
      #1;
      if (cyc >= WORDS + 1) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = cyc;
          chk({tag, ".sum"}, {1'b0, sum}, {1'b0, exp_sum});
          chk({tag, ".cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, exp_cout});
          chk({tag, ".busy_done"}, {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
        end
      end
      if (cyc == WORDS + 2)
        chk({tag, ".busy_fall"}, {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b0});
    end
    chk({tag, ".done_cycle"}, (W+1)'(first_done), (W+1)'(WORDS + 1));
    chk({tag, ".done_count"}, (W+1)'(done_cnt), (W+1)'(1));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   ref_v;
    logic [W-1:0] pat_a;
    logic [W-1:0] pat_b;
    logic [W-1:0] pat_s;
    int           seen;

    // Reset state
    #12;
    chk("reset.busy", {{W{1'b0}}, busy}, '0);
    chk("reset.done", {{W{1'b0}}, done}, '0);
    chk("reset.sum", {1'b0, sum}, '0);
    chk("reset.cout", {{W{1'b0}}, cout}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full carry ripple
    do_op("ripple", {W{1'b1}}, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Cross-word carry
    do_op("xword", {{(W-32){1'b0}}, 32'hFFFF_FFFF}, {{(W-1){1'b0}}, 1'b1}, 1'b0, 1'b0, 1'b0,
          {32'h0, 32'h0, 32'h1, 32'h0}, 1'b0);

    // Independent per-word add
    for (int i = 0; i < WORDS; i++) begin
      pat_a[i*32 +: 32] = 32'h001F_001F;
      pat_b[i*32 +: 32] = 32'h0006_000C;
      pat_s[i*32 +: 32] = 32'h0025_002B;
    end
    do_op("perword", pat_a, pat_b, 1'b0, 1'b0, 1'b0, pat_s, 1'b0);

    // Busy protection: start hammered with new operands during RUN and DONE
    ra = rnd_op(); rb = rnd_op(); rc = 1'b1;
    ref_v = model(ra, rb, rc, 1'b0);
    do_op("busyprot", ra, rb, rc, 1'b0, 1'b1, ref_v[W-1:0], ref_v[W]);

    // Reset mid-RUN after edge 2
    @(negedge clk);
    a = rnd_op(); b = rnd_op(); cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", {{W{1'b0}}, busy}, '0);
    chk("midrst.done", {{W{1'b0}}, done}, '0);
    chk("midrst.sum", {1'b0, sum}, '0);
    chk("midrst.cout", {{W{1'b0}}, cout}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < WORDS + 4; cyc++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("midrst.no_done", (W+1)'(seen), '0);

    ra = rnd_op(); rb = rnd_op();
    ref_v = model(ra, rb, 1'b0, 1'b0);
    do_op("postrst", ra, rb, 1'b0, 1'b0, 1'b0, ref_v[W-1:0], ref_v[W]);

    // Randomized additions against the reference model
    for (int t = 0; t < 6; t++) begin
      ra = rnd_op(); rb = rnd_op(); rc = 1'($urandom_range(0, 1));
      if (t == 0) rb = ~ra;
      ref_v = model(ra, rb, rc, 1'b0);
      do_op($sformatf("rand%0d", t), ra, rb, rc, 1'b0, 1'b0, ref_v[W-1:0], ref_v[W]);
    end

`ifdef CIA_SEQ_SUB_EN
    do_op("sub_neg", 128'd5, 128'd7, 1'b0, 1'b1, 1'b0,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0);
    do_op("sub_pos", 128'd7, 128'd5, 1'b0, 1'b1, 1'b0, 128'd2, 1'b1);
    for (int t = 0; t < 4; t++) begin
      ra = rnd_op(); rb = rnd_op(); rc = 1'($urandom_range(0, 1));
      ref_v = model(ra, rb, rc, 1'b1);
      do_op($sformatf("rsub%0d", t), ra, rb, rc, 1'b1, 1'b0, ref_v[W-1:0], ref_v[W]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
